// File: rtl/shift_sequencer.sv
// Variable-amount shift/rotate controller: one single-step shifter_rotator
// applied once per clock for 0-7 steps, with busy/done handshake.
//
// Ports (shift_sequencer):
//   clk, rst_n    clock, async active-low reset
//   start         request strobe, accepted in IDLE or DONE
//   data_in[7:0]  operand captured on accept
//   op[1:0]       00 rotr, 01 rotl, 10 shr, 11 shl
//   amount[2:0]   number of single steps
//   busy          steps remain (RUN)
//   done          one-cycle result strobe (DONE)
//   data_out[7:0] working/result register

module shifter_rotator (
   input  logic [7:0] data_in,
   input  logic [1:0] select,
   output logic [7:0] data_out
);
   always_comb begin
      data_out = data_in;
      unique case (select)
         2'b00: data_out = {data_in[0], data_in[7:1]};
         2'b01: data_out = {data_in[6:0], data_in[7]};
         2'b10: data_out = {1'b0, data_in[7:1]};
         2'b11: data_out = {data_in[6:0], 1'b0};
         default: data_out = data_in;
      endcase
   end
endmodule

module shift_sequencer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data_in,
   input  logic [1:0] op,
   input  logic [2:0] amount,
   output logic       busy,
   output logic       done,
   output logic [7:0] data_out
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] data_q, data_d;
   logic [1:0] op_q, op_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] step;

   shifter_rotator u_step (
      .data_in  (data_q),
      .select   (op_q),
      .data_out (step)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         data_q  <= 8'h00;
         op_q    <= 2'b00;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               data_d  = data_in;
               op_d    = op;
               cnt_d   = amount;
               state_d = (amount != 3'd0) ? S_RUN : S_DONE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            // start is deliberately ignored while stepping
            data_d = step;
            cnt_d  = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy     = (state_q == S_RUN);
   assign done     = (state_q == S_DONE);
   assign data_out = data_q;
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-step controller for the 8-bit single-step `shifter_rotator` datapath. It accepts a shift/rotate request with a step count of 0–7 and applies the single-step operation once per clock through one internal `shifter_rotator` instance. It reports progress with `busy`/`done` and holds the result until the next accepted request. It sits between a requester (lab top or FSM) and the combinational shifter, turning it into a variable-amount shifter.

## Interface
- No parameters. Data width is fixed at 8 and step count width at 3, matching `shifter_rotator`.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request strobe; sampled on rising edge.
- `data_in`  in  8  operand, captured when `start` is accepted.
- `op`  in  2  operation, captured with `data_in`. Encoding equals `shifter_rotator` `select`:
  - 00 rotate toward LSB (bit0→bit7)
  - 01 rotate toward MSB (bit7→bit0)
  - 10 shift toward LSB, zero into bit7
  - 11 shift toward MSB, zero into bit0
- `amount`  in  3  number of single steps, 0–7, captured with `data_in`.
- `busy`  out  1  high while steps remain (state RUN).
- `done`  out  1  one-cycle pulse; `data_out` holds the final result.
- `data_out`  out  8  working/result register.

## Operation
- Registers:
  - `data_q` (8 bits), drives `data_out`.
  - `op_q` (2 bits), drives shifter `select`.
  - `cnt` (3 bits).
  - `state`.
- Shifter input is `data_q`; its output is the next-step value.
- States:
  - IDLE: waits for a request.
  - RUN: applies one step per cycle.
  - DONE: result presented.
- IDLE or DONE, `start`=1:
  - Load `data_q`←`data_in`, `op_q`←`op`, `cnt`←`amount`.
  - Next state is RUN if `amount`≠0, else DONE.
- IDLE, `start`=0: hold all registers.
- DONE, `start`=0: go to IDLE, hold `data_q`.
- RUN, each edge:
  - `data_q`←shifter output; `cnt`←`cnt`−1.
  - If `cnt`==1, next state is DONE; else stay in RUN.
- `start` in RUN is ignored. Inputs are not re-sampled and no queueing occurs.
- `start` in DONE is accepted, so back-to-back requests are allowed. `done` is still high in that cycle.
- Changes to `data_in`/`op`/`amount` after acceptance have no effect.
- `amount`=0: result equals `data_in`, `done` still pulses.
- Rotates by 7 give the inverse direction by 1. Shifts by 7 leave only one original bit.

## Timing
- Reset values:
  - `state`=IDLE, `data_q`=0x00, `op_q`=00, `cnt`=0.
  - `busy`=0, `done`=0, `data_out`=0x00.
- Reset asserted mid-RUN aborts immediately with no `done` pulse. The first request after release is processed normally.
- Outputs are decoded from registered state only, with no input-to-output combinational path:
  - `busy` = (state==RUN).
  - `done` = (state==DONE).
- Request accepted at edge E0 with `amount`=N:
  - `busy` is high for cycles after E0 … E(N−1), i.e. N cycles.
  - `done` is high for exactly the one cycle after EN.
  - Latency from the accepting edge to `done` is N+1 edges. For N=0, `done` follows E0 directly and `busy` never rises.
- `data_out` shows intermediate values during RUN. It is valid from the `done` cycle and stable until the next accepted `start`.
- Throughput: one request per N+1 cycles at best.

## Test plan
- Reset, then `data_in`=0x81, `op`=00, `amount`=3, `start` for 1 cycle -> `busy` high for 3 cycles, `done` on 4th cycle after start edge, `data_out`=0x30.
- `data_in`=0x81, `op`=01, `amount`=1 -> `data_out`=0x03.
- `data_in`=0xF0, `op`=10, `amount`=7 -> `data_out`=0x01 after 8 edges.
- `data_in`=0x0F, `op`=11, `amount`=4 -> `data_out`=0xF0.
- `amount`=0 with `data_in`=0xA5 -> `done` 1 edge later, `busy` never high, `data_out`=0xA5.
- Robustness sequence:
  - 0x81/op 00/amount 5; pulse `start` with 0xFF mid-RUN -> ignored, result 0x0C.
  - `start` held in DONE with 0x01/op 01/amount 2 -> accepted, result 0x04.
  - Assert `rst_n`=0 mid-RUN -> all outputs 0 immediately, no `done`.
